rate_counter: RTL and testbench

RATE_COUNTER -- requirements
Module: rate_counter

---
 rtl/rate_counter_pkg.sv | 16 +
 rtl/rate_divider.sv | 61 ++++++
 rtl/rate_counter.sv | 83 ++++++++
 tb/tb_rate_counter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/rate_counter_pkg.sv
// Shared constants for the rate counter: default divider reloads and speed codes.
package rate_counter_pkg;

  localparam int RATE0_DEF = 0;
  localparam int RATE1_DEF = 499;
  localparam int RATE2_DEF = 999;
  localparam int RATE3_DEF = 1999;

  typedef enum logic [1:0] {
    SPD_FAST = 2'd0,
    SPD_1    = 2'd1,
    SPD_2    = 2'd2,
    SPD_3    = 2'd3
  } speed_e;

endpackage

// File: rtl/rate_divider.sv
// Programmable tick divider: counts DivCount down to zero, reloads from the
// rate selected by Speed, and holds its state while paused.
module rate_divider
  import rate_counter_pkg::*;
#(
  parameter int DIV_W = 11,
  parameter int RATE0 = RATE0_DEF,
  parameter int RATE1 = RATE1_DEF,
  parameter int RATE2 = RATE2_DEF,
  parameter int RATE3 = RATE3_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_speed,
  input  logic       i_run,
  input  logic       i_reload,
  output logic       o_expire,
  output logic       o_tick
);

  logic [DIV_W-1:0] r_div;
  speed_e           r_speed_q;
  logic             r_tick;
  logic [DIV_W-1:0] w_rate;
  logic             w_spd_chg;
  logic             w_zero;

  always_comb begin
    w_rate = DIV_W'(RATE0);
    case (speed_e'(i_speed))
      SPD_FAST: w_rate = DIV_W'(RATE0);
      SPD_1:    w_rate = DIV_W'(RATE1);
      SPD_2:    w_rate = DIV_W'(RATE2);
      SPD_3:    w_rate = DIV_W'(RATE3);
      default:  w_rate = DIV_W'(RATE0);
    endcase
  end

  assign w_spd_chg = (speed_e'(i_speed) != r_speed_q);
  assign w_zero    = (r_div == '0);
  // A speed change restarts the period instead of ticking.
  assign o_expire  = !i_reload && i_run && !w_spd_chg && w_zero;
  assign o_tick    = r_tick;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div     <= DIV_W'(RATE0);
      r_speed_q <= SPD_FAST;
      r_tick    <= 1'b0;
    end else begin
      r_tick <= o_expire;
      if (i_reload || (i_run && (w_spd_chg || w_zero))) begin
        r_div     <= w_rate;
        r_speed_q <= speed_e'(i_speed);
      end else if (i_run) begin
        r_div <= r_div - 1'b1;
      end
    end
  end

endmodule

// File: rtl/rate_counter.sv
// Up/down wrapping counter advanced by a programmable-rate tick.
// Optional synchronous parallel load enabled by RATE_COUNTER_LOAD_EN.
module rate_counter
  import rate_counter_pkg::*;
#(
  parameter int CNT_W   = 4,
  parameter int CNT_MAX = 2**CNT_W - 1,
  parameter int DIV_W   = 11,
  parameter int RATE0   = RATE0_DEF,
  parameter int RATE1   = RATE1_DEF,
  parameter int RATE2   = RATE2_DEF,
  parameter int RATE3   = RATE3_DEF
) (
  input  logic             i_ClockIn,
  input  logic             i_Resetn,
  input  logic [1:0]       i_Speed,
  input  logic             i_Run,
  input  logic             i_Down,
`ifdef RATE_COUNTER_LOAD_EN
  input  logic             i_Load,
  input  logic [CNT_W-1:0] i_LoadValue,
`endif
  output logic [CNT_W-1:0] o_CounterValue,
  output logic             o_Tick,
  output logic             o_Wrap
);

  localparam logic [CNT_W-1:0] MAXV = CNT_W'(CNT_MAX);

  logic [CNT_W-1:0] r_cnt;
  logic             r_wrap;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_expire;

`ifdef RATE_COUNTER_LOAD_EN
  assign w_load     = i_Load;
  assign w_load_val = (i_LoadValue > MAXV) ? MAXV : i_LoadValue;
`else
  assign w_load     = 1'b0;
  assign w_load_val = '0;
`endif

  rate_divider #(
    .DIV_W (DIV_W),
    .RATE0 (RATE0),
    .RATE1 (RATE1),
    .RATE2 (RATE2),
    .RATE3 (RATE3)
  ) u_div (
    .i_clk    (i_ClockIn),
    .i_rst_n  (i_Resetn),
    .i_speed  (i_Speed),
    .i_run    (i_Run),
    .i_reload (w_load),
    .o_expire (w_expire),
    .o_tick   (o_Tick)
  );

  always_ff @(posedge i_ClockIn or negedge i_Resetn) begin
    if (!i_Resetn) begin
      r_cnt  <= '0;
      r_wrap <= 1'b0;
    end else if (w_load) begin
      r_cnt  <= w_load_val;
      r_wrap <= 1'b0;
    end else if (w_expire) begin
      if (i_Down) begin
        r_wrap <= (r_cnt == '0);
        r_cnt  <= (r_cnt == '0) ? MAXV : r_cnt - 1'b1;
      end else begin
        r_wrap <= (r_cnt == MAXV);
        r_cnt  <= (r_cnt == MAXV) ? '0 : r_cnt + 1'b1;
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign o_CounterValue = r_cnt;
  assign o_Wrap         = r_wrap;

endmodule

// File: tb/tb_rate_counter.sv
// Bench for rate_counter: three configurations checked against a rule-level model.
module tb_rate_counter;

`ifdef RATE_COUNTER_LOAD_EN
  localparam bit LOAD_EN = 1'b1;
`else
  localparam bit LOAD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] speed = 2'd0;
  logic       run = 1'b0;
  logic       down0 = 1'b0;
  logic       down1 = 1'b0;
  logic       load = 1'b0;
  logic [3:0] lv = 4'd0;

  logic [3:0] cnt0, cnt1;
  logic [0:0] cnt2;
  logic       tick0, tick1, tick2, wrap0, wrap1, wrap2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rate_counter u_dut0 (
    .i_ClockIn(clk), .i_Resetn(rst_n), .i_Speed(speed), .i_Run(run), .i_Down(down0),
`ifdef RATE_COUNTER_LOAD_EN
    .i_Load(load), .i_LoadValue(lv),
`endif
    .o_CounterValue(cnt0), .o_Tick(tick0), .o_Wrap(wrap0));

  rate_counter #(.CNT_W(4), .CNT_MAX(9), .DIV_W(4),
                 .RATE0(0), .RATE1(1), .RATE2(2), .RATE3(5)) u_dut1 (
    .i_ClockIn(clk), .i_Resetn(rst_n), .i_Speed(speed), .i_Run(run), .i_Down(down1),
`ifdef RATE_COUNTER_LOAD_EN
    .i_Load(load), .i_LoadValue(lv),
`endif
    .o_CounterValue(cnt1), .o_Tick(tick1), .o_Wrap(wrap1));

  rate_counter #(.CNT_W(1), .CNT_MAX(0), .DIV_W(2),
                 .RATE0(1), .RATE1(0), .RATE2(3), .RATE3(2)) u_dut2 (
    .i_ClockIn(clk), .i_Resetn(rst_n), .i_Speed(speed), .i_Run(run), .i_Down(down1),
`ifdef RATE_COUNTER_LOAD_EN
    .i_Load(load), .i_LoadValue(lv[0:0]),
`endif
    .o_CounterValue(cnt2), .o_Tick(tick2), .o_Wrap(wrap2));

  // Reference model: per instance, cycles left in the current period and count.
  int MAXV [3] = '{15, 9, 0};
  int RT [3][4] = '{'{0, 499, 999, 1999}, '{0, 1, 2, 5}, '{1, 0, 3, 2}};
  int m_cnt [3], m_left [3], m_sq [3], m_tick [3], m_wrap [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_left[i] = RT[i][0]; m_sq[i] = 0; m_tick[i] = 0; m_wrap[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      int lvv, dn, sp;
      lvv = (i == 2) ? int'(lv[0]) : int'(lv);
      dn  = (i == 0) ? int'(down0) : int'(down1);
      sp  = int'(speed);
      m_tick[i] = 0; m_wrap[i] = 0;
      if (LOAD_EN && load) begin
        m_cnt[i] = (lvv > MAXV[i]) ? MAXV[i] : lvv;
        m_left[i] = RT[i][sp]; m_sq[i] = sp;
      end else if (!run) begin
      end else if (sp != m_sq[i]) begin
        m_sq[i] = sp; m_left[i] = RT[i][sp];
      end else if (m_left[i] == 0) begin
        m_left[i] = RT[i][sp];
        m_tick[i] = 1;
        if (dn != 0) begin
          m_wrap[i] = (m_cnt[i] == 0);
          m_cnt[i] = (m_cnt[i] == 0) ? MAXV[i] : m_cnt[i] - 1;
        end else begin
          m_wrap[i] = (m_cnt[i] == MAXV[i]);
          m_cnt[i] = (m_cnt[i] == MAXV[i]) ? 0 : m_cnt[i] + 1;
        end
      end else begin
        m_left[i] = m_left[i] - 1;
      end
    end
  endtask

  task automatic check_all();
    chk("cnt0", 32'(cnt0), m_cnt[0]);  chk("tick0", 32'(tick0), m_tick[0]); chk("wrap0", 32'(wrap0), m_wrap[0]);
    chk("cnt1", 32'(cnt1), m_cnt[1]);  chk("tick1", 32'(tick1), m_tick[1]); chk("wrap1", 32'(wrap1), m_wrap[1]);
    chk("cnt2", 32'(cnt2), m_cnt[2]);  chk("tick2", 32'(tick2), m_tick[2]); chk("wrap2", 32'(wrap2), m_wrap[2]);
  endtask

  // Advance one clock; inputs change only at the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    int gap, guard;
    // Reset state before any clock edge.
    model_reset();
    #1;
    chk("rst_cnt0", 32'(cnt0), 0);
    chk("rst_tick0", 32'(tick0), 0);
    chk("rst_wrap0", 32'(wrap0), 0);
    @(negedge clk);

    // Fastest rate counting: up on dut0, down on dut1 (CNT_MAX=9).
    speed = 2'd0; run = 1'b1; down0 = 1'b0; down1 = 1'b1;
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      cycle();
      chk("seq_up", 32'(cnt0), k % 16);
      chk("seq_up_wrap", 32'(wrap0), (k == 16) ? 1 : 0);
      chk("seq_dn", 32'(cnt1), (10 - (k % 10)) % 10);
      chk("seq_dn_wrap", 32'(wrap1), ((k % 10) == 1) ? 1 : 0);
    end

    // Speed 1 from reset.
    speed = 2'd1; down0 = 1'b0; down1 = 1'b0;
    do_reset();
    for (int k = 1; k <= 1501; k++) cycle();
    chk("spd1_cnt", 32'(cnt0), 3);

    // Speed 1 -> 3 while DivCount = 200.
    guard = 0;
    while (m_left[0] != 200 && guard < 600) begin cycle(); guard++; end
    chk("find_div200", 32'(m_left[0]), 200);
    speed = 2'd3;
    cycle();
    chk("chg_notick", 32'(tick0), 0);
    gap = 0;
    do begin cycle(); gap++; end while (!tick0 && gap < 2100);
    chk("spd3_gap", 32'(gap), 2000);

    // Randomized traffic.
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 99) < 3) speed = 2'($urandom_range(0, 3));
        run   = ($urandom_range(0, 9) != 0);
        down0 = ($urandom_range(0, 49) == 0) ? ~down0 : down0;
        down1 = $urandom_range(0, 1);
        load  = ($urandom_range(0, 29) == 0);
        lv    = 4'($urandom_range(0, 15));
        cycle();
      end
    end
    load = 1'b0;

`ifdef RATE_COUNTER_LOAD_EN
    // Load on a tick cycle of dut1 (RATE0=0 ticks every cycle).
    speed = 2'd0; run = 1'b1; down1 = 1'b0;
    do_reset();
    cycle(); cycle();
    load = 1'b1; lv = 4'd7;
    cycle();
    chk("load_cnt", 32'(cnt1), 7);
    chk("load_tick", 32'(tick1), 0);
    chk("load_wrap", 32'(wrap1), 0);
    load = 1'b0;
    cycle();
    chk("load_next", 32'(cnt1), 8);
    load = 1'b1; lv = 4'd15; run = 1'b0;
    cycle();
    chk("load_sat", 32'(cnt1), 9);
    load = 1'b0; run = 1'b1;
`endif

    // Asynchronous reset in the middle of a clock phase.
    speed = 2'd0; run = 1'b1; down0 = 1'b0;
    for (int k = 0; k < 5; k++) cycle();
    @(posedge clk);
    model_step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_cnt0", 32'(cnt0), 0);
    chk("arst_tick0", 32'(tick0), 0);
    chk("arst_cnt1", 32'(cnt1), 0);
    chk("arst_tick1", 32'(tick1), 0);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
